// File: rtl/ram_dma_ci_if.sv
// CI handshake bundle for the scratchpad RAM.
// master: CPU/DMA side drives the request; slave: RAM answers.
interface ram_dma_ci_if;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [31:0] result;
    logic        done;

    modport master (
        output start, ciN, valueA, valueB,
        input  result, done
    );

    modport slave (
        input  start, ciN, valueA, valueB,
        output result, done
    );
endinterface

// File: rtl/ram_dma_ci.sv
// 512 x 32 single-port scratchpad answering CI memory ops.
// Ports: clock, reset (async low), bus (slave: start/ciN/valueA/valueB -> result/done).
module ram_dma_ci #(
    parameter logic [7:0] customId = 8'h00
) (
    input logic          clock,
    input logic          reset,
    ram_dma_ci_if.slave  bus
);

    logic [31:0] mem [512];

    logic        pending_q, pending_d;
    logic        was_write_q, was_write_d;
    logic [31:0] rd_q, rd_d;

    logic        accept;
    logic        we;
    logic [8:0]  addr;
    logic        unused_bits;

    assign addr = bus.valueA[8:0];
    assign we   = bus.valueA[9];

    // Bits above the selector carry no meaning here.
    assign unused_bits = ^bus.valueA[31:13];

    // Non-zero selectors address the DMA register file, not us.
    assign accept = bus.start
                 && (bus.ciN == customId)
                 && (bus.valueA[12:10] == 3'b000);

    always_comb begin
        pending_d   = accept;
        was_write_d = was_write_q;
        rd_d        = rd_q;
        if (accept) begin
            was_write_d = we;
            if (!we) begin
                rd_d = mem[addr];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q   <= 1'b0;
            was_write_q <= 1'b0;
            rd_q        <= '0;
        end else begin
            pending_q   <= pending_d;
            was_write_q <= was_write_d;
            rd_q        <= rd_d;
        end
    end

    // Contents survive reset, so the array has no reset branch.
    always_ff @(posedge clock) begin
        if (reset && accept && we) begin
            mem[addr] <= bus.valueB;
        end
    end

    assign bus.done   = pending_q;
    assign bus.result = (pending_q && !was_write_q) ? rd_q : 32'h0;

endmodule

// File: tb/tb_ram_dma_ci.sv
// Directed bench for ram_dma_ci.
// Drives on falling edges, checks done/result on the next falling edge.
module tb_ram_dma_ci;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    ram_dma_ci_if bus_if ();

    ram_dma_ci #(.customId(8'h00)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic s, input logic [7:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        bus_if.start  = s;
        bus_if.ciN    = c;
        bus_if.valueA = a;
        bus_if.valueB = b;
    endtask

    task automatic check(input string tag, input logic exp_done,
                         input logic [31:0] exp_res);
        n_cmp++;
        assert (bus_if.done === exp_done) else begin
            n_err++;
            $error("FAIL %s done: got %0b want %0b", tag, bus_if.done, exp_done);
        end
        n_cmp++;
        assert (bus_if.result === exp_res) else begin
            n_err++;
            $error("FAIL %s result: got %08h want %08h", tag, bus_if.result, exp_res);
        end
    endtask

    task automatic step(input string tag, input logic s, input logic [7:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic exp_done, input logic [31:0] exp_res);
        drive(s, c, a, b);
        @(negedge clock);
        check(tag, exp_done, exp_res);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        drive(1'b0, 8'h00, 32'h0, 32'h0);
        repeat (2) @(negedge clock);
        check("reset_hold", 1'b0, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        check("after_release", 1'b0, 32'h0);

        step("wr5",       1'b1, 8'h00, 32'h0000_0205, 32'hDEAD_BEEF, 1'b1, 32'h0);
        step("rd5",       1'b1, 8'h00, 32'h0000_0005, 32'h0,         1'b1, 32'hDEAD_BEEF);
        step("idle1",     1'b0, 8'h00, 32'h0,         32'h0,         1'b0, 32'h0);

        step("wr000",     1'b1, 8'h00, 32'h0000_0200, 32'h1111_1111, 1'b1, 32'h0);
        step("wr1ff",     1'b1, 8'h00, 32'h0000_03FF, 32'h2222_2222, 1'b1, 32'h0);
        step("rd000",     1'b1, 8'h00, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_1111);
        step("rd1ff",     1'b1, 8'h00, 32'h0000_01FF, 32'h0,         1'b1, 32'h2222_2222);
        step("rd21ff",    1'b1, 8'h00, 32'h0000_21FF, 32'h0,         1'b1, 32'h2222_2222);
        step("idle2",     1'b0, 8'h00, 32'h0,         32'h0,         1'b0, 32'h0);

        step("bad_ci",    1'b1, 8'h01, 32'h0000_0205, 32'h0,         1'b0, 32'h0);
        step("rd5_a",     1'b1, 8'h00, 32'h0000_0005, 32'h0,         1'b1, 32'hDEAD_BEEF);
        step("bad_sel",   1'b1, 8'h00, 32'h0000_0605, 32'h0,         1'b0, 32'h0);
        step("rd5_b",     1'b1, 8'h00, 32'h0000_0005, 32'h0,         1'b1, 32'hDEAD_BEEF);
        step("bad_sel2",  1'b1, 8'h00, 32'h0000_0E05, 32'h0,         1'b0, 32'h0);

        step("b2b_w7",    1'b1, 8'h00, 32'h0000_0207, 32'hA5A5_A5A5, 1'b1, 32'h0);
        step("b2b_w8",    1'b1, 8'h00, 32'h0000_0208, 32'h0F0F_0F0F, 1'b1, 32'h0);
        step("b2b_r7",    1'b1, 8'h00, 32'h0000_0007, 32'h0,         1'b1, 32'hA5A5_A5A5);
        step("b2b_r8",    1'b1, 8'h00, 32'h0000_0008, 32'h0,         1'b1, 32'h0F0F_0F0F);
        step("idle3",     1'b0, 8'h00, 32'h0,         32'h0,         1'b0, 32'h0);

        drive(1'b1, 8'h00, 32'h0000_0005, 32'h0);
        @(posedge clock);
        #2;
        drive(1'b0, 8'h00, 32'h0, 32'h0);
        check("pre_rst", 1'b1, 32'hDEAD_BEEF);
        reset = 1'b0;
        #1;
        check("rst_async", 1'b0, 32'h0);
        @(negedge clock);
        check("rst_held", 1'b0, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst1", 1'b0, 32'h0);
        @(negedge clock);
        check("post_rst2", 1'b0, 32'h0);

        step("rd5_keep",  1'b1, 8'h00, 32'h0000_0005, 32'h0,         1'b1, 32'hDEAD_BEEF);
        step("rd7_keep",  1'b1, 8'h00, 32'h0000_0007, 32'h0,         1'b1, 32'hA5A5_A5A5);
        step("idle4",     1'b0, 8'h00, 32'h0,         32'h0,         1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
